pc_gen: RTL and testbench
=========================

# pc_gen

Parametrised program-counter generator for the fetch stage. It replaces the fixed 32-bit PC register with a width-generic block that handshakes with instruction fetch, holds on back-pressure, and buffers a redirect that arrives while fetch is stalled. It sits between decode/branch resolution and the instruction-memory port, with optional exception entry and return support.

## Interface
- XLEN, 32, address width in bits (≥ 8)
- RESET_VEC, 0, PC value while and after reset
- EXC_VEC, 'h80, exception entry address (used only with PC_EPC_EN)
- Clk  in  1  rising-edge clock
- Reset_n  in  1  asynchronous, active-low reset
- Ctrl_valid  in  1  decode-stage control fields below are valid this cycle
- PCsrc  in  3  next-PC select: add4, j, jr, branch; other codes behave as add4
- Branch  in  1  branch taken; used only when PCsrc = branch
- NPC  in  XLEN  jump/branch target
- j_r1  in  XLEN  register-indirect target
- Exc  in  1  exception request (PC_EPC_EN)
- ERet  in  1  exception return (PC_EPC_EN)
- If_ready  in  1  fetch accepts current PC
- Pc_valid  out  1  PC output is valid
- PC  out  XLEN  current fetch address
- EPC  out  XLEN  saved exception PC
- Misalign  out  1  one-cycle pulse: the applied target had its low 2 bits nonzero

## Operation
- States: INIT (in reset), RUN, HOLD (pending redirect buffered).
- fire = Pc_valid & If_ready.
- Redirect request, in priority order: Exc → EXC_VEC; ERet → EPC; Ctrl_valid & PCsrc=j → NPC; Ctrl_valid & PCsrc=jr → j_r1; Ctrl_valid & PCsrc=branch & Branch → NPC. Anything else is no request.
- RUN with fire: PC ← request target if there is one, else PC+4 (mod 2^XLEN, wraps silently).
- RUN with no fire: PC holds. A request is stored in pend, and the state moves to HOLD.
- HOLD: a new request overwrites pend (latest wins; Exc beats same-cycle others). On fire, PC ← pend, then RUN.
- Alignment: every applied target has bits [1:0] forced to 0. Misalign pulses in the cycle after the PC update.
- Exc: EPC ← current PC, captured at the request edge even if fire is low.
- ERet and Exc in the same cycle: Exc wins.

## Timing
- Reset (asynchronous): PC = RESET_VEC, Pc_valid = 0, EPC = 0, Misalign = 0, pend = 0, state INIT.
- First rising edge after Reset_n deasserts: Pc_valid = 1, state RUN, PC = RESET_VEC.
- PC updates on the fire edge and is visible the same cycle after that edge. Latency from request to new PC: 1 edge when If_ready = 1.
- Pc_valid stays 1 from then on; a stall is signalled only by If_ready.
- Reset asserted mid-HOLD discards pend immediately.

## Configuration
- PC_EPC_EN defined: Exc, ERet, EPC and EXC_VEC are functional.
- PC_EPC_EN undefined: Exc and ERet are ignored, EPC is tied to 0, and no EPC register is built.

## Structure
- pc_pkg holds the PCsrc encodings (npc_add4 = 0, npc_j = 1, npc_jr = 2, npc_branch = 3) and the state enum.
- Sub-module pc_redirect_arb: combinational priority select producing {req, target}. pc_gen holds the registers and the FSM.

## Test plan
- Release reset with If_ready = 1 → Pc_valid rises after the first edge; PC runs 0x0, 0x4, 0x8, 0xC.
- Hold If_ready = 0 for 3 cycles at PC 0x8 → PC stays 0x8; resumes at 0xC.
- Branch taken, NPC = 0x40, If_ready = 0 → PC stays, state HOLD. Then If_ready = 1 → PC 0x40, then 0x44.
- In HOLD with pend 0x40, then jr j_r1 = 0x200 → after fire PC = 0x200 (latest wins).
- PC_EPC_EN, Exc at PC 0x44 → PC 0x80 and EPC 0x44. Then ERet → PC 0x44.
- jr to 0x102 → PC 0x100 and a one-cycle Misalign pulse. Reset_n low in HOLD → PC = RESET_VEC immediately.

Source files
------------

// File: rtl/pc_pkg.sv
// pc_pkg: next-PC select encodings and FSM state constants shared by the
// program-counter generator and its redirect arbiter.
package pc_pkg;

  localparam logic [2:0] NPC_ADD4   = 3'd0;
  localparam logic [2:0] NPC_J      = 3'd1;
  localparam logic [2:0] NPC_JR     = 3'd2;
  localparam logic [2:0] NPC_BRANCH = 3'd3;

  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

endpackage

// File: rtl/pc_redirect_arb.sv
// pc_redirect_arb: combinational priority select of the next redirect target.
// Exception entry/return take part only when PC_EPC_EN is defined.
module pc_redirect_arb
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN    = 32,
  parameter logic [XLEN-1:0] EXC_VEC = XLEN'('h80)
) (
  input  logic            exc_i,
  input  logic            eret_i,
  input  logic [XLEN-1:0] epc_i,
  input  logic            ctrl_valid_i,
  input  logic [2:0]      pcsrc_i,
  input  logic            branch_i,
  input  logic [XLEN-1:0] npc_i,
  input  logic [XLEN-1:0] jr1_i,
  output logic            req_o,
  output logic [XLEN-1:0] target_o
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    req_o    = 1'b0;
    target_o = '0;
`ifdef PC_EPC_EN
    if (exc_i) begin
      req_o    = 1'b1;
      target_o = EXC_VEC;
    end else if (eret_i) begin
      req_o    = 1'b1;
      target_o = epc_i;
    end else
`endif
    if (ctrl_valid_i) begin
      case (pcsrc_i)
        NPC_J: begin
          req_o    = 1'b1;
          target_o = npc_i;
        end
        NPC_JR: begin
          req_o    = 1'b1;
          target_o = jr1_i;
        end
        NPC_BRANCH: begin
          req_o    = branch_i;
          target_o = npc_i;
        end
        default: ;
      endcase
    end
  end

`ifndef PC_EPC_EN
  logic unused_epc;
  assign unused_epc = ^{exc_i, eret_i, epc_i, EXC_VEC};
`endif

endmodule

// File: rtl/pc_gen.sv
// pc_gen: width-generic fetch PC register with ready handshake and buffered
// redirect. Define PC_EPC_EN to build exception entry/return and the EPC register.
module pc_gen
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter logic [XLEN-1:0] EXC_VEC   = XLEN'('h80)
) (
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic            Ctrl_valid,
  input  logic [2:0]      PCsrc,
  input  logic            Branch,
  input  logic [XLEN-1:0] NPC,
  input  logic [XLEN-1:0] j_r1,
  input  logic            Exc,
  input  logic            ERet,
  input  logic            If_ready,
  output logic            Pc_valid,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] EPC,
  output logic            Misalign
);

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_q, pend_d;
  logic            valid_q, valid_d;
  logic            mis_q, mis_d;
  logic [XLEN-1:0] epc_val;
  logic            req;
  logic [XLEN-1:0] target;
  logic            fire;
  logic            apply;
  logic [XLEN-1:0] applied;

  assign fire = valid_q & If_ready;

  pc_redirect_arb #(
    .XLEN    (XLEN),
    .EXC_VEC (EXC_VEC)
  ) u_arb (
    .exc_i        (Exc),
    .eret_i       (ERet),
    .epc_i        (epc_val),
    .ctrl_valid_i (Ctrl_valid),
    .pcsrc_i      (PCsrc),
    .branch_i     (Branch),
    .npc_i        (NPC),
    .jr1_i        (j_r1),
    .req_o        (req),
    .target_o     (target)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    valid_d = valid_q;
    mis_d   = 1'b0;
    apply   = 1'b0;
    applied = '0;
    case (state_q)
      ST_INIT: begin
        state_d = ST_RUN;
        valid_d = 1'b1;
      end
      ST_RUN: begin
        if (fire) begin
          if (req) begin
            apply   = 1'b1;
            applied = target;
          end else begin
            pc_d = pc_q + XLEN'(4);
          end
        end else if (req) begin
          pend_d  = target;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // A request arriving on the fire cycle is the latest one, so it wins.
        if (req) pend_d = target;
        if (fire) begin
          apply   = 1'b1;
          applied = req ? target : pend_q;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
    if (apply) begin
      pc_d  = {applied[XLEN-1:2], 2'b00};
      mis_d = |applied[1:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_INIT;
      pc_q    <= RESET_VEC;
      pend_q  <= '0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
    end
  end

`ifdef PC_EPC_EN
  logic [XLEN-1:0] epc_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)            epc_q <= '0;
    else if (Exc && valid_q) epc_q <= pc_q;
  end

  assign epc_val = epc_q;
`else
  assign epc_val = '0;
`endif

  assign Pc_valid = valid_q;
  assign PC       = pc_q;
  assign EPC      = epc_val;
  assign Misalign = mis_q;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed and randomized check of pc_gen against a queue-based
// behavioural model of the fetch PC rules.
module tb_pc_gen;

  localparam int unsigned XLEN      = 32;
  localparam logic [31:0] RESET_VEC = 32'h0;
  localparam logic [31:0] EXC_VEC   = 32'h80;
`ifdef PC_EPC_EN
  localparam bit EPC_EN = 1'b1;
`else
  localparam bit EPC_EN = 1'b0;
`endif

  logic        Clk, Reset_n;
  logic        Ctrl_valid, Branch, Exc, ERet, If_ready;
  logic [2:0]  PCsrc;
  logic [31:0] NPC, j_r1;
  logic        Pc_valid, Misalign;
  logic [31:0] PC, EPC;

  pc_gen #(
    .XLEN      (XLEN),
    .RESET_VEC (RESET_VEC),
    .EXC_VEC   (EXC_VEC)
  ) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .Ctrl_valid (Ctrl_valid),
    .PCsrc      (PCsrc),
    .Branch     (Branch),
    .NPC        (NPC),
    .j_r1       (j_r1),
    .Exc        (Exc),
    .ERet       (ERet),
    .If_ready   (If_ready),
    .Pc_valid   (Pc_valid),
    .PC         (PC),
    .EPC        (EPC),
    .Misalign   (Misalign)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int n_vec  = 0;
  int n_fail = 0;

  // Model state: architectural PC, valid flag, saved EPC, misalign flag and
  // at most one outstanding redirect waiting for fetch to accept.
  logic [31:0] m_pc, m_epc;
  logic        m_valid, m_mis;
  logic [31:0] m_pend[$];
  logic [31:0] n_pc, n_epc;
  logic        n_valid, n_mis;
  logic [31:0] n_pend[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    check("Pc_valid", {31'd0, Pc_valid}, {31'd0, m_valid});
    check("PC",       PC,                m_pc);
    check("EPC",      EPC,               m_epc);
    check("Misalign", {31'd0, Misalign}, {31'd0, m_mis});
  endtask

  task automatic model_reset();
    m_pc    = RESET_VEC;
    m_epc   = '0;
    m_valid = 1'b0;
    m_mis   = 1'b0;
    m_pend.delete();
  endtask

  task automatic model_next();
    bit          r;
    logic [31:0] t;
    bit          have;
    logic [31:0] a;
    n_pc = m_pc; n_epc = m_epc; n_valid = m_valid; n_mis = 1'b0;
    n_pend = m_pend;
    if (!Reset_n) begin
      n_pc = RESET_VEC; n_epc = '0; n_valid = 1'b0;
      n_pend.delete();
    end else if (!m_valid) begin
      n_valid = 1'b1;
    end else begin
      r = 1'b0; t = '0;
      if (EPC_EN && Exc)            begin r = 1'b1; t = EXC_VEC; end
      else if (EPC_EN && ERet)      begin r = 1'b1; t = m_epc;   end
      else if (Ctrl_valid && PCsrc == 3'd1) begin r = 1'b1; t = NPC;  end
      else if (Ctrl_valid && PCsrc == 3'd2) begin r = 1'b1; t = j_r1; end
      else if (Ctrl_valid && PCsrc == 3'd3 && Branch) begin r = 1'b1; t = NPC; end
      if (EPC_EN && Exc) n_epc = m_pc;
      if (If_ready) begin
        have = 1'b1; a = '0;
        if (r) a = t;
        else if (n_pend.size() != 0) a = n_pend[0];
        else have = 1'b0;
        n_pend.delete();
        if (have) begin
          n_pc  = a & 32'hFFFF_FFFC;
          n_mis = (a % 4) != 0;
        end else begin
          n_pc = m_pc + 32'd4;
        end
      end else if (r) begin
        n_pend.delete();
        n_pend.push_back(t);
      end
    end
  endtask

  // Called with inputs settled after a falling edge; returns at the next falling edge.
  task automatic cycle();
    model_next();
    @(posedge Clk);
    #1;
    m_pc = n_pc; m_epc = n_epc; m_valid = n_valid; m_mis = n_mis; m_pend = n_pend;
    compare_all();
    @(negedge Clk);
  endtask

  task automatic idle_inputs(input logic rdy);
    Ctrl_valid = 1'b0; PCsrc = 3'd0; Branch = 1'b0;
    NPC = '0; j_r1 = '0; Exc = 1'b0; ERet = 1'b0; If_ready = rdy;
  endtask

  task automatic set_ctrl(input logic [2:0] src, input logic br,
                          input logic [31:0] npc, input logic [31:0] jr, input logic rdy);
    idle_inputs(rdy);
    Ctrl_valid = 1'b1; PCsrc = src; Branch = br; NPC = npc; j_r1 = jr;
  endtask

  task automatic assert_reset();
    Reset_n = 1'b0;
    model_reset();
    #1;
    compare_all();
  endtask

  initial begin
    #10ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset_n = 1'b0;
    idle_inputs(1'b1);
    model_reset();
    @(negedge Clk);
    assert_reset();
    check("reset PC", PC, 32'h0);
    check("reset valid", {31'd0, Pc_valid}, 32'd0);
    cycle();
    Reset_n = 1'b1;

    cycle();
    check("first edge valid", {31'd0, Pc_valid}, 32'd1);
    check("first edge PC", PC, 32'h0);
    cycle(); check("run 4", PC, 32'h4);
    cycle(); check("run 8", PC, 32'h8);

    idle_inputs(1'b0);
    repeat (3) cycle();
    check("stall holds 8", PC, 32'h8);
    idle_inputs(1'b1);
    cycle(); check("resume C", PC, 32'hC);

    set_ctrl(3'd3, 1'b1, 32'h40, 32'h0, 1'b0);
    cycle(); check("branch stalled", PC, 32'hC);
    idle_inputs(1'b1);
    cycle(); check("branch applied", PC, 32'h40);
    cycle(); check("after branch", PC, 32'h44);

    set_ctrl(3'd3, 1'b1, 32'h40, 32'h0, 1'b0);
    cycle();
    set_ctrl(3'd2, 1'b0, 32'h0, 32'h200, 1'b0);
    cycle(); check("hold overwrite", PC, 32'h44);
    idle_inputs(1'b1);
    cycle(); check("latest wins", PC, 32'h200);

    set_ctrl(3'd2, 1'b0, 32'h0, 32'h102, 1'b1);
    cycle();
    check("jr aligned", PC, 32'h100);
    check("misalign pulse", {31'd0, Misalign}, 32'd1);
    idle_inputs(1'b1);
    cycle();
    check("misalign clears", {31'd0, Misalign}, 32'd0);
    check("after jr", PC, 32'h104);

    idle_inputs(1'b1); Exc = 1'b1;
    cycle();
`ifdef PC_EPC_EN
    check("exc entry", PC, 32'h80);
    check("exc epc", EPC, 32'h104);
    idle_inputs(1'b1); ERet = 1'b1;
    cycle();
    check("eret return", PC, 32'h104);
`else
    check("exc ignored", PC, 32'h108);
    check("epc tied", EPC, 32'h0);
`endif

    set_ctrl(3'd1, 1'b0, 32'h40, 32'h0, 1'b0);
    cycle();
    idle_inputs(1'b1);
    assert_reset();
    check("reset in hold PC", PC, 32'h0);
    check("reset in hold valid", {31'd0, Pc_valid}, 32'd0);
    cycle();
    Reset_n = 1'b1;
    cycle();
    cycle(); check("pend discarded", PC, 32'h4);

    for (int i = 0; i < 3000; i++) begin
      Ctrl_valid = ($urandom_range(0, 1) == 1);
      PCsrc      = 3'($urandom_range(0, 7));
      Branch     = ($urandom_range(0, 1) == 1);
      NPC        = $urandom;
      j_r1       = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        NPC[1:0]  = 2'b00;
        j_r1[1:0] = 2'b00;
      end
      Exc        = ($urandom_range(0, 19) == 0);
      ERet       = ($urandom_range(0, 19) == 0);
      If_ready   = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 149) == 0) begin
        assert_reset();
        cycle();
        Reset_n = 1'b1;
      end else begin
        cycle();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
